wb_dbg_master: RTL and testbench

- UART-driven Wishbone debug initiator.
- Decodes a byte-stream command protocol from a UART receiver and issues single 32-bit Wishbone read/write cycles as an interconnect master (conbus master port 2).
- Returns status and read data as bytes to a UART transmitter.
- Gives host-side peek/poke access to bram0, sram0, uart0 and timer0 without CPU involvement.

---
 rtl/wb_dbg_master_if.sv | 22 ++
 rtl/wb_dbg_master.sv | 193 +++++++++++++++++++
 tb/tb_wb_dbg_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dbg_master_if.sv
// Wishbone master-side signal bundle for the UART debug initiator.
interface wb_dbg_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_dbg_master.sv
// UART byte-stream to Wishbone single-cycle debug initiator.
// Command byte, 4 address bytes and (writes only) 4 data bytes, all MSB
// first, launch one 32-bit cycle; a status byte and, for successful reads,
// 4 read-data bytes are returned over the transmitter.
module wb_dbg_master #(
  parameter int unsigned byte_timeout = 5000000,
  parameter int unsigned bus_timeout  = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_stb,
  output logic [7:0]      tx_data,
  output logic            tx_stb,
  input  logic            tx_busy,
  wb_dbg_master_if.master wb,
  output logic            busy
);

  localparam logic [7:0]  CMD_WR   = 8'h01;
  localparam logic [7:0]  CMD_RD   = 8'h02;
  localparam logic [7:0]  CMD_PING = 8'h03;
  localparam logic [7:0]  RSP_ACK  = 8'h06;
  localparam logic [7:0]  RSP_NAK  = 8'h15;
  localparam logic [31:0] BYTE_TO  = 32'(byte_timeout);
  localparam logic [31:0] BUS_TO   = 32'(bus_timeout);

  typedef enum logic [2:0] {IDLE, ADR, DAT, BUS, RSP, RDAT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  code_q, code_d;
  logic        rd_ok_q, rd_ok_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_stb_q, tx_stb_d;
  logic        busy_q, busy_d;

  // The transmitter may only be pulsed when idle; its busy flag lags the
  // pulse by one cycle, so the cycle right after a pulse never sends.
  logic tx_ready;
  assign tx_ready = !tx_stb_q && !tx_busy;

  // Next-state and next-output computation for the command/bus/response FSM.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    rd_ok_d   = rd_ok_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_stb) begin
          rd_ok_d = 1'b0;
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            cmd_d   = rx_data;
            idx_d   = 2'd0;
            cnt_d   = 32'd0;
            state_d = ADR;
          end else begin
            code_d  = (rx_data == CMD_PING) ? RSP_ACK : RSP_NAK;
            state_d = RSP;
          end
        end
      end
      ADR, DAT: begin
        if (rx_stb) begin
          cnt_d = 32'd0;
          idx_d = idx_q + 2'd1;
          if (state_q == ADR) adr_d  = {adr_q[23:0], rx_data};
          else                wdat_d = {wdat_q[23:0], rx_data};
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = (state_q == ADR && cmd_q == CMD_WR) ? DAT : BUS;
          end
        end else if (cnt_q + 32'd1 == BYTE_TO) begin
          // Host went quiet mid-command: drop the partial command silently.
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BUS: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          sel_d = 4'hF;
          we_d  = (cmd_q == CMD_WR);
          cnt_d = 32'd0;
        end else if (wb.wb_err_i || wb.wb_ack_i || (cnt_q + 32'd1 == BUS_TO)) begin
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          we_d    = 1'b0;
          cnt_d   = 32'd0;
          state_d = RSP;
          code_d  = RSP_NAK;
          if (!wb.wb_err_i && wb.wb_ack_i) begin
            code_d = RSP_ACK;
            if (cmd_q == CMD_RD) begin
              rdat_d  = wb.wb_dat_i;
              rd_ok_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RSP: begin
        if (tx_ready) begin
          tx_stb_d  = 1'b1;
          tx_data_d = code_q;
          idx_d     = 2'd0;
          state_d   = rd_ok_q ? RDAT : IDLE;
        end
      end
      RDAT: begin
        if (tx_ready) begin
          tx_stb_d  = 1'b1;
          tx_data_d = rdat_q[31:24];
          rdat_d    = {rdat_q[23:0], 8'h00};
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cmd_q     <= 8'h00;
      adr_q     <= 32'h0;
      wdat_q    <= 32'h0;
      rdat_q    <= 32'h0;
      idx_q     <= 2'd0;
      cnt_q     <= 32'd0;
      code_q    <= 8'h00;
      rd_ok_q   <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      tx_data_q <= 8'h00;
      tx_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      rd_ok_q   <= rd_ok_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_stb      = tx_stb_q;
  assign busy        = busy_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = wdat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_dbg_master.sv
// Bench for wb_dbg_master: directed protocol scenarios followed by random
// transactions, compared against a response-rule reference model.
module tb_wb_dbg_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic       busy;

  wb_dbg_master_if wb();

  wb_dbg_master #(.byte_timeout(100), .bus_timeout(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_data (rx_data),
    .rx_stb  (rx_stb),
    .tx_data (tx_data),
    .tx_stb  (tx_stb),
    .tx_busy (tx_busy),
    .wb      (wb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour: 0 ack, 1 err, 2 silent, 3 ack+err together.
  int          slv_mode  = 0;
  int          slv_delay = 1;
  logic [31:0] slv_rdata = 32'h0;
  int          stb_n;

  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_dat_i = 32'h0;
    stb_n = 0;
    forever begin
      @(negedge clk);
      if (wb.wb_cyc_o === 1'b1 && wb.wb_stb_o === 1'b1) begin
        stb_n++;
        wb.wb_ack_i = (slv_mode == 0 || slv_mode == 3) && stb_n == slv_delay;
        wb.wb_err_i = (slv_mode == 1 || slv_mode == 3) && stb_n == slv_delay;
        wb.wb_dat_i = (stb_n == slv_delay) ? slv_rdata : $urandom;
      end else begin
        stb_n = 0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
      end
    end
  end

  // Bus monitor: records each cycle and checks signals hold while it lasts.
  int          ncyc = 0;
  int          cyc_len = 0;
  logic [31:0] m_adr, m_dat;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        prev_cyc = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (wb.wb_cyc_o === 1'b1) begin
        if (!prev_cyc) begin
          ncyc++;
          cyc_len = 0;
          m_adr = wb.wb_adr_o;
          m_dat = wb.wb_dat_o;
          m_we  = wb.wb_we_o;
          m_sel = wb.wb_sel_o;
        end else begin
          chk("adr_hold", wb.wb_adr_o, m_adr);
          chk("dat_hold", wb.wb_dat_o, m_dat);
          chk("we_sel_hold", {27'h0, wb.wb_we_o, wb.wb_sel_o}, {27'h0, m_we, m_sel});
        end
        chk("stb_eq_cyc", {31'h0, wb.wb_stb_o}, 32'h1);
        cyc_len++;
      end
      prev_cyc = (wb.wb_cyc_o === 1'b1);
    end
  end

  // Transmitter model: busy rises the cycle after a pulse, lasts a few cycles.
  logic [7:0] txq[$];
  logic       tx_pend = 1'b0;
  int         tx_rem  = 0;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_stb === 1'b1) begin
        chk("tx_while_busy", {31'h0, tx_busy}, 32'h0);
        txq.push_back(tx_data);
      end
      if (tx_pend) begin
        tx_busy = 1'b1;
        tx_rem  = $urandom_range(1, 5);
        tx_pend = 1'b0;
      end else if (tx_rem > 0) begin
        tx_rem--;
        if (tx_rem == 0) tx_busy = 1'b0;
      end
      if (tx_stb === 1'b1) tx_pend = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge clk);
    rx_stb  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_bound", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
  endtask

  // One host transaction; expected response built from the protocol rules.
  task automatic run_txn(input string tag, input logic [7:0] cmd, input logic [31:0] adr,
                         input logic [31:0] dat, input int mode, input int delay,
                         input logic [31:0] rdata, input int gap_max, input bit lat);
    logic [7:0] expq[$];
    bit         is_bus;
    int         n0;
    slv_mode  = mode;
    slv_delay = delay;
    slv_rdata = rdata;
    txq.delete();
    n0 = ncyc;
    is_bus = (cmd == 8'h01 || cmd == 8'h02);
    send_byte(cmd);
    if (is_bus) begin
      for (int i = 3; i >= 0; i--) begin
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        send_byte(adr[i*8 +: 8]);
      end
      if (cmd == 8'h01) begin
        for (int i = 3; i >= 0; i--) begin
          repeat ($urandom_range(0, gap_max)) @(negedge clk);
          send_byte(dat[i*8 +: 8]);
        end
      end
    end
    if (lat) begin
      chk({tag, "_lat0"}, {31'h0, wb.wb_cyc_o}, 32'h0);
      @(negedge clk);
      chk({tag, "_lat1"}, {31'h0, wb.wb_stb_o}, 32'h1);
      @(negedge clk);
      chk({tag, "_lat2"}, {31'h0, wb.wb_cyc_o}, 32'h0);
    end
    wait_idle();
    if (!is_bus)                    expq = '{(cmd == 8'h03) ? 8'h06 : 8'h15};
    else if (mode != 0)             expq = '{8'h15};
    else if (cmd == 8'h01)          expq = '{8'h06};
    else expq = '{8'h06, rdata[31:24], rdata[23:16], rdata[15:8], rdata[7:0]};
    chk({tag, "_ncyc"}, 32'(ncyc - n0), is_bus ? 32'd1 : 32'd0);
    if (is_bus) begin
      chk({tag, "_adr"}, m_adr, adr);
      chk({tag, "_we_sel"}, {27'h0, m_we, m_sel}, {27'h0, (cmd == 8'h01), 4'hF});
      if (cmd == 8'h01) chk({tag, "_dat"}, m_dat, dat);
      chk({tag, "_cyclen"}, 32'(cyc_len), (mode == 2) ? 32'd8 : 32'(delay));
    end
    chk({tag, "_ntx"}, 32'(txq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      chk({tag, "_txbyte"}, {24'h0, txq[i]}, {24'h0, expq[i]});
  endtask

  initial begin
    int n0;
    int k;
    reset_n = 1'b0;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", {23'h0, tx_stb, tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_bus", {26'h0, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o[2:0]}, 32'h0);
    chk("rst_sel", {28'h0, wb.wb_sel_o}, 32'h0);
    chk("rst_adr", wb.wb_adr_o, 32'h0);
    chk("rst_dat", wb.wb_dat_o, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn("ping", 8'h03, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1'b0);
    run_txn("write", 8'h01, 32'h40000010, 32'hDEADBEEF, 0, 2, 32'h0, 0, 1'b0);
    run_txn("read", 8'h02, 32'h00000004, 32'h0, 0, 1, 32'h12345678, 0, 1'b1);
    run_txn("err", 8'h02, 32'h70000000, 32'h0, 1, 1, 32'hCAFEF00D, 0, 1'b0);
    run_txn("bus_to", 8'h02, 32'h70000000, 32'h0, 2, 1, 32'h0, 0, 1'b0);
    run_txn("ack_err", 8'h01, 32'h10000000, 32'h55AA55AA, 3, 3, 32'h0, 0, 1'b0);
    run_txn("bad_cmd", 8'hA5, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1'b0);

    // Byte gap: partial command abandoned exactly byte_timeout cycles later.
    txq.delete();
    n0 = ncyc;
    send_byte(8'h01);
    send_byte(8'h40);
    repeat (99) @(negedge clk);
    chk("gap_busy_before", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("gap_busy_after", {31'h0, busy}, 32'h0);
    repeat (5) @(negedge clk);
    chk("gap_ntx", 32'(txq.size()), 32'h0);
    chk("gap_ncyc", 32'(ncyc - n0), 32'h0);
    run_txn("gap_ping", 8'h03, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1'b0);

    // Reset while a cycle is outstanding.
    txq.delete();
    slv_mode = 2;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h20);
    k = 0;
    while (wb.wb_cyc_o !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_cyc_up", {31'h0, wb.wb_cyc_o}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", {28'h0, wb.wb_cyc_o, wb.wb_stb_o, tx_stb, busy}, 32'h0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_rst_ntx", 32'(txq.size()), 32'h0);
    run_txn("rst_ping", 8'h03, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1'b0);

    // Random transactions.
    for (int i = 0; i < 40; i++) begin
      int          r, m;
      logic [7:0]  c;
      r = $urandom_range(0, 9);
      m = $urandom_range(0, 9);
      if (r < 4)       c = 8'h01;
      else if (r < 8)  c = 8'h02;
      else if (r == 8) c = 8'h03;
      else             c = 8'($urandom_range(4, 255));
      m = (m < 6) ? 0 : (m < 8) ? 1 : (m == 8) ? 2 : 3;
      run_txn("rand", c, $urandom, $urandom, m, $urandom_range(1, 6), $urandom, 4, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
